konwersja_u2_zm: RTL and testbench

Sequential converter from two's complement (U2) to sign-magnitude (ZM). It is the reverse path of the execution unit's ZM→U2 conversion. A bit-serial negation engine with valid/ready handshakes on input and output processes one magnitude bit per clock. It sits between the U2 arithmetic core and any consumer that expects sign-magnitude results, and flags values that ZM cannot represent.

---
 rtl/konwersja_u2_zm.sv | 118 +++++++++++
 tb/tb_konwersja_u2_zm.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/konwersja_u2_zm.sv
// Two's complement (U2) to sign-magnitude (ZM) converter with valid/ready handshakes.
// Default build negates one magnitude bit per clock; define KONWERSJA_U2_ZM_FAST_EN for single-cycle conversion.
module konwersja_u2_zm #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_argA,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_error
);
  localparam int MW = WIDTH - 1;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH - 1) : 1;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t state, state_next;
  logic   accept;

  // Gating with reset keeps o_ready low during the reset cycle and lets reset win any handshake.
  assign o_ready = (state == IDLE) && !i_rst;
  assign o_valid = (state == DONE);
  assign accept  = i_valid && o_ready;

`ifndef KONWERSJA_U2_ZM_FAST_EN
  logic [MW-1:0] operand, mag, mag_next;
  logic [CW-1:0] cnt;
  logic          sign, seen_one, bit_in, bit_out, last_bit;

  // Serial negation: copy bits up to and including the first 1, invert every bit after it.
  always_comb begin
    bit_in   = operand[0];
    bit_out  = bit_in ^ (sign & seen_one);
    mag_next = (mag >> 1) | (MW'(bit_out) << (MW - 1));
    last_bit = (cnt == CW'(WIDTH - 2));
  end
`else
  logic [MW-1:0] fast_mag;
  logic          fast_err;

  always_comb begin
    fast_mag = i_argA[WIDTH-1] ? (~i_argA[MW-1:0] + MW'(1)) : i_argA[MW-1:0];
    fast_err = (i_argA == {1'b1, {MW{1'b0}}});
  end
`endif

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: default assigned first so no path through the case infers a latch.
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifndef KONWERSJA_U2_ZM_FAST_EN
          state_next = CONV;
`else
          state_next = DONE;
`endif
        end
      end
`ifndef KONWERSJA_U2_ZM_FAST_EN
      CONV:    if (last_bit) state_next = DONE;
`endif
      DONE:    if (i_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifndef KONWERSJA_U2_ZM_FAST_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      operand  <= '0;
      sign     <= 1'b0;
      seen_one <= 1'b0;
      cnt      <= '0;
      mag      <= '0;
      o_result <= '0;
      o_error  <= 1'b0;
    end else if (accept) begin
      operand  <= i_argA[MW-1:0];
      sign     <= i_argA[WIDTH-1];
      seen_one <= 1'b0;
      cnt      <= '0;
      mag      <= '0;
    end else if (state == CONV) begin
      operand  <= operand >> 1;
      seen_one <= seen_one | bit_in;
      mag      <= mag_next;
      cnt      <= cnt + CW'(1);
      // A negative operand whose magnitude wraps to zero can only be the most-negative value.
      if (last_bit) begin
        o_error  <= sign && (mag_next == '0);
        o_result <= (sign && (mag_next == '0)) ? '0 : {sign, mag_next};
      end
    end
  end
`else
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_result <= '0;
      o_error  <= 1'b0;
    end else if (accept) begin
      o_error  <= fast_err;
      o_result <= fast_err ? '0 : {i_argA[WIDTH-1], fast_mag};
    end
  end
`endif

endmodule

// File: tb/tb_konwersja_u2_zm.sv
// Self-checking bench for konwersja_u2_zm: directed, random, backpressure, reset-abort and back-to-back cases.
// Expected values come from a signed-integer model; latency follows KONWERSJA_U2_ZM_FAST_EN.
module tb_konwersja_u2_zm;
  localparam int WIDTH = 32;
`ifdef KONWERSJA_U2_ZM_FAST_EN
  localparam int LAT    = 0;          // edges after the accept edge before o_valid is seen
  localparam int PERIOD = 2;
`else
  localparam int LAT    = WIDTH - 1;
  localparam int PERIOD = WIDTH + 1;
`endif

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_valid = 1'b0;
  logic             o_ready;
  logic [WIDTH-1:0] i_argA = '0;
  logic             o_valid;
  logic             i_ready = 1'b0;
  logic [WIDTH-1:0] o_result;
  logic             o_error;

  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc   = 0;

  konwersja_u2_zm #(.WIDTH(WIDTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_argA(i_argA), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1);
  end

  // Reference: interpret as a signed integer, take the absolute value, pack sign + magnitude.
  function automatic void model(input logic [WIDTH-1:0] a, output logic [WIDTH-1:0] r,
                                output logic e);
    longint     v;
    logic [63:0] m;
    v = longint'($signed(a));
    if (v == -(longint'(1) << (WIDTH - 1))) begin
      r = '0;
      e = 1'b1;
    end else if (v < 0) begin
      m = 64'(-v);
      r = {1'b1, m[WIDTH-2:0]};
      e = 1'b0;
    end else begin
      r = a;
      e = 1'b0;
    end
  endfunction

  task automatic op(input logic [WIDTH-1:0] a, input string tag);
    logic [WIDTH-1:0] er;
    logic             ee;
    int               n;
    model(a, er, ee);
    @(negedge i_clk);
    n_cmp++;
    if (o_ready !== 1'b1) begin
      n_bad++; $display("FAIL %s ready_idle: got %b want 1", tag, o_ready);
    end
    i_argA = a; i_valid = 1'b1; i_ready = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0; i_argA = $urandom;
    n = 0;
    while (!o_valid && n < LAT + 5) begin
      n_cmp++;
      if (o_ready !== 1'b0) begin
        n_bad++; $display("FAIL %s ready_busy: got %b want 0 at cycle %0d", tag, o_ready, n);
      end
      @(negedge i_clk);
      n++;
    end
    n_cmp++;
    if (n !== LAT) begin
      n_bad++; $display("FAIL %s latency: got %0d want %0d", tag, n, LAT);
    end
    n_cmp++;
    if (o_result !== er || o_error !== ee) begin
      n_bad++; $display("FAIL %s result: a=%h got %h/%b want %h/%b", tag, a, o_result, o_error, er, ee);
    end
    n_cmp++;
    if (o_ready !== 1'b0) begin
      n_bad++; $display("FAIL %s ready_done: got %b want 0", tag, o_ready);
    end
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
    n_cmp++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_bad++; $display("FAIL %s handoff: valid=%b ready=%b want 0/1", tag, o_valid, o_ready);
    end
    n_cmp++;
    if (o_result !== er || o_error !== ee) begin
      n_bad++; $display("FAIL %s hold_idle: got %h/%b want %h/%b", tag, o_result, o_error, er, ee);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_valid = 1'b1; i_argA = 32'hFFFF_FFFB;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    n_cmp++;
    if (o_ready !== 1'b0 || o_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_hs: ready=%b valid=%b want 0/0", o_ready, o_valid);
    end
    n_cmp++;
    if (o_result !== '0 || o_error !== 1'b0) begin
      n_bad++; $display("FAIL reset_out: got %h/%b want 0/0", o_result, o_error);
    end
    i_rst = 1'b0; i_valid = 1'b0;
    @(negedge i_clk);
    n_cmp++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_idle: ready=%b valid=%b want 1/0", o_ready, o_valid);
    end
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] vals [8] = '{32'h0000_0005, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'h0000_0000,
                                   32'h8000_0000, 32'h8000_0001, 32'h7FFF_FFFF, 32'h0000_0001};
    foreach (vals[i]) op(vals[i], $sformatf("directed%0d", i));
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] a;
    for (int i = 0; i < 40; i++) begin
      case (i % 8)
        0:       a = 32'h8000_0000;
        1:       a = 32'hFFFF_FFFF;
        2:       a = 32'h8000_0000 | WIDTH'($urandom_range(0, 3));
        default: a = $urandom;
      endcase
      op(a, $sformatf("random%0d", i));
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] er;
    logic             ee;
    int               n;
    bit               stray;
    model(32'h8000_0000, er, ee);
    @(negedge i_clk);
    i_argA = 32'h8000_0000; i_valid = 1'b1; i_ready = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    n = 0;
    while (!o_valid && n < LAT + 5) begin
      @(negedge i_clk);
      n++;
    end
    n_cmp++;
    if (o_valid !== 1'b1) begin
      n_bad++; $display("FAIL bp_timeout: o_valid=%b after %0d cycles", o_valid, n);
    end
    for (int i = 0; i < 10; i++) begin
      i_valid = i[0]; i_argA = 32'h0000_0005;
      @(negedge i_clk);
      n_cmp++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_result !== er || o_error !== ee) begin
        n_bad++;
        $display("FAIL bp_hold%0d: v=%b r=%b res=%h err=%b want 1/0/%h/%b",
                 i, o_valid, o_ready, o_result, o_error, er, ee);
      end
    end
    i_valid = 1'b0; i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
    n_cmp++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_release: valid=%b ready=%b want 0/1", o_valid, o_ready);
    end
    stray = 1'b0;
    repeat (LAT + 3) begin
      @(negedge i_clk);
      if (o_valid !== 1'b0 || o_ready !== 1'b1) stray = 1'b1;
    end
    n_cmp++;
    if (stray !== 1'b0) begin
      n_bad++; $display("FAIL bp_no_accept: got stray=%b want 0", stray);
    end
  endtask

  task automatic test_reset_mid();
    bit stray;
    @(negedge i_clk);
    i_argA = 32'hFFFF_FFFB; i_valid = 1'b1; i_ready = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (15) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    n_cmp++;
    if (o_valid !== 1'b0 || o_ready !== 1'b0 || o_result !== '0 || o_error !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid: v=%b r=%b res=%h err=%b want 0/0/0/0", o_valid, o_ready, o_result, o_error);
    end
    i_rst = 1'b0;
    stray = 1'b0;
    repeat (LAT + 3) begin
      @(negedge i_clk);
      if (o_valid !== 1'b0) stray = 1'b1;
    end
    n_cmp++;
    if (stray !== 1'b0) begin
      n_bad++; $display("FAIL rst_partial: got stray=%b want 0", stray);
    end
    op(32'h0000_0007, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] vals [4] = '{32'hFFFF_FFFB, 32'h0000_1234, 32'h8000_0000, 32'h8765_4321};
    logic [WIDTH-1:0] er;
    logic             ee;
    longint           stamp [4];
    int               t;
    @(negedge i_clk);
    i_valid = 1'b1; i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      t = 0;
      while (!o_ready && t < PERIOD + 5) begin
        @(negedge i_clk);
        t++;
      end
      i_argA = vals[i];
      stamp[i] = cyc + 1;
      model(vals[i], er, ee);
      @(negedge i_clk);
      t = 0;
      while (!o_valid && t < LAT + 5) begin
        @(negedge i_clk);
        t++;
      end
      n_cmp++;
      if (o_valid !== 1'b1 || o_result !== er || o_error !== ee) begin
        n_bad++;
        $display("FAIL b2b%0d: v=%b res=%h err=%b want 1/%h/%b", i, o_valid, o_result, o_error, er, ee);
      end
      if (i > 0) begin
        n_cmp++;
        if (stamp[i] - stamp[i-1] !== longint'(PERIOD)) begin
          n_bad++;
          $display("FAIL b2b_period%0d: got %0d want %0d", i, stamp[i] - stamp[i-1], PERIOD);
        end
      end
    end
    @(negedge i_clk);
    i_valid = 1'b0; i_ready = 1'b0;
    n_cmp++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_bad++; $display("FAIL b2b_end: valid=%b ready=%b want 0/1", o_valid, o_ready);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
